// File: rtl/seg_pkg.sv
// Shared constants for the display path (seg_scan and svn_seg) and the
// commit-time digit formatting used when a conversion lands in the bank.
package seg_pkg;

   localparam logic [3:0] SEG_BLANK  = 4'hF;
   localparam logic [3:0] SEG_ERR    = 4'hE;
   localparam int         SEG_NDIG   = 4;
   localparam int         SEG_MAXVAL = 9999;

   localparam int         SEG_BINW   = 14;
   localparam int         SEG_BCDW   = 4 * SEG_NDIG;
   localparam logic [3:0] SEG_NITER  = 4'd14;

   typedef enum logic [1:0] {
      B2B_IDLE,
      B2B_SHIFT,
      B2B_DONE
   } b2b_state_t;

   // Error code wins over blanking; otherwise leading zeros above digit 0 go blank.
   function automatic logic [SEG_BCDW-1:0] seg_commit_digits(
      input logic [SEG_BCDW-1:0] bcd,
      input logic                ovf,
      input logic                blank_lz
   );
      logic [SEG_BCDW-1:0] r_dig;
      logic                lead;
      r_dig = bcd;
      lead  = 1'b1;
      if (ovf) begin
         r_dig = {SEG_NDIG{SEG_ERR}};
      end else if (blank_lz) begin
         for (int i = SEG_NDIG - 1; i >= 1; i--) begin
            if (lead && (r_dig[i*4 +: 4] == 4'd0)) begin
               r_dig[i*4 +: 4] = SEG_BLANK;
            end else begin
               lead = 1'b0;
            end
         end
      end
      return r_dig;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 14 shift iterations, one per clock.
// bcd/done are presented combinationally during the final iteration.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// B2B_IDLE  | waiting for start
// B2B_SHIFT | one add-3/shift iteration per cycle, r_cnt counts 13 down to 0
// B2B_DONE  | one cycle after the last iteration; accepts start like IDLE
module bin2bcd_seq
   import seg_pkg::*;
(
   input  logic                CLK,
   input  logic                RST,
   input  logic                start,
   input  logic [SEG_BINW-1:0] bin,
   output logic                busy,
   output logic                done,
   output logic [SEG_BCDW-1:0] bcd,
   output logic                ovf
);

   localparam int WORK_W = SEG_BCDW + SEG_BINW;

   b2b_state_t        r_state;
   b2b_state_t        w_state_nxt;
   logic [WORK_W-1:0] r_work;
   logic [WORK_W-1:0] w_work_nxt;
   logic [WORK_W-1:0] w_work_adj;
   logic [WORK_W-1:0] w_work_step;
   logic [3:0]        r_cnt;
   logic [3:0]        w_cnt_nxt;
   logic              r_ovf;
   logic              w_ovf_nxt;

   always_comb begin
      w_work_adj = r_work;
      for (int i = 0; i < SEG_NDIG; i++) begin
         if (r_work[SEG_BINW + i*4 +: 4] >= 4'd5) begin
            w_work_adj[SEG_BINW + i*4 +: 4] = r_work[SEG_BINW + i*4 +: 4] + 4'd3;
         end
      end
      w_work_step = {w_work_adj[WORK_W-2:0], 1'b0};
   end

   always_comb begin
      w_state_nxt = r_state;
      w_work_nxt  = r_work;
      w_cnt_nxt   = r_cnt;
      w_ovf_nxt   = r_ovf;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         B2B_IDLE, B2B_DONE: begin
            w_state_nxt = B2B_IDLE;
            if (start) begin
               w_state_nxt = B2B_SHIFT;
               w_work_nxt  = {{SEG_BCDW{1'b0}}, bin};
               w_cnt_nxt   = SEG_NITER - 4'd1;
               w_ovf_nxt   = (bin > SEG_BINW'(SEG_MAXVAL));
            end
         end
         B2B_SHIFT: begin
            busy       = 1'b1;
            w_work_nxt = w_work_step;
            if (r_cnt == 4'd0) begin
               done        = 1'b1;
               w_state_nxt = B2B_DONE;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         default: w_state_nxt = B2B_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= B2B_IDLE;
         r_work  <= '0;
         r_cnt   <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_work  <= w_work_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ovf   <= w_ovf_nxt;
      end
   end

   assign bcd = w_work_step[WORK_W-1:SEG_BINW];
   assign ovf = r_ovf;

endmodule

// File: rtl/seg_scan.sv
// 4-digit multiplexed display front end: loads a binary value, converts it to
// BCD, commits it atomically to a digit bank, and scans the bank onto D/AN.
module seg_scan
   import seg_pkg::*;
#(
   parameter int CLK_DIV  = 50000,
   parameter bit BLANK_LZ = 1'b1
)
(
   input  logic                CLK,
   input  logic                RST,
   input  logic [SEG_BINW-1:0] VAL,
   input  logic                LOAD,
   output logic                BUSY,
   output logic [3:0]          D,
   output logic [3:0]          AN
);

   localparam int               PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

   logic [PRE_W-1:0]    r_pre;
   logic [1:0]          r_idx;
   logic [SEG_BCDW-1:0] r_bank;
   logic [3:0]          r_an1;

   logic                w_start;
   logic                w_busy;
   logic                w_done;
   logic                w_ovf;
   logic [SEG_BCDW-1:0] w_bcd;
   logic [3:0]          w_digit;

   assign w_start = LOAD & ~w_busy;

   bin2bcd_seq u_b2b (
      .CLK   (CLK),
      .RST   (RST),
      .start (w_start),
      .bin   (VAL),
      .busy  (w_busy),
      .done  (w_done),
      .bcd   (w_bcd),
      .ovf   (w_ovf)
   );

   assign BUSY    = w_busy;
   assign w_digit = r_bank[{r_idx, 2'b00} +: 4];

   // AN takes one extra stage so it switches with svn_seg's registered segments.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_pre  <= '0;
         r_idx  <= '0;
         r_bank <= {SEG_NDIG{SEG_BLANK}};
         D      <= SEG_BLANK;
         r_an1  <= 4'hF;
         AN     <= 4'hF;
      end else begin
         if (r_pre == PRE_LAST) begin
            r_pre <= '0;
            r_idx <= r_idx + 2'd1;
         end else begin
            r_pre <= r_pre + 1'b1;
         end
         if (w_done) begin
            r_bank <= seg_commit_digits(w_bcd, w_ovf, BLANK_LZ);
         end
         D     <= w_digit;
         r_an1 <= ~(4'b0001 << r_idx);
         AN    <= r_an1;
      end
   end

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: two instances (blanking on/off) share stimulus;
// expected banks are queued at load time and compared against the scanned D/AN.
module tb_seg_scan;

   localparam int CLK_DIV = 4;

   logic        clk  = 1'b0;
   logic        rst  = 1'b1;
   logic        load = 1'b0;
   logic [13:0] val  = '0;
   logic        busy, busy_nb;
   logic [3:0]  d, an, d_nb, an_nb;

   int checks = 0;
   int errors = 0;

   logic [15:0] sb_q[$];
   logic [15:0] sb_nb_q[$];

   always #5 clk = ~clk;

   seg_scan #(.CLK_DIV(CLK_DIV), .BLANK_LZ(1'b1)) dut (
      .CLK  (clk),
      .RST  (rst),
      .VAL  (val),
      .LOAD (load),
      .BUSY (busy),
      .D    (d),
      .AN   (an)
   );

   seg_scan #(.CLK_DIV(CLK_DIV), .BLANK_LZ(1'b0)) dut_nb (
      .CLK  (clk),
      .RST  (rst),
      .VAL  (val),
      .LOAD (load),
      .BUSY (busy_nb),
      .D    (d_nb),
      .AN   (an_nb)
   );

   function automatic logic [15:0] exp_digits(input int v, input bit blank);
      logic [15:0] r;
      int          x;
      if (v > 9999) return 16'hEEEE;
      x = v;
      for (int i = 0; i < 4; i++) begin
         r[i*4 +: 4] = 4'(x % 10);
         x = x / 10;
      end
      if (blank) begin
         for (int i = 3; i >= 1; i--) begin
            if (r[i*4 +: 4] == 4'd0) r[i*4 +: 4] = 4'hF;
            else break;
         end
      end
      return r;
   endfunction

   function automatic int an_index(input logic [3:0] a);
      case (a)
         4'b1110: return 0;
         4'b1101: return 1;
         4'b1011: return 2;
         4'b0111: return 3;
         default: return -1;
      endcase
   endfunction

   task automatic do_load(input logic [13:0] v, input bit accept);
      @(negedge clk);
      val  = v;
      load = 1'b1;
      if (accept) begin
         sb_q.push_back(exp_digits(int'(v), 1'b1));
         sb_nb_q.push_back(exp_digits(int'(v), 1'b0));
      end
      @(negedge clk);
      load = 1'b0;
   endtask

   // D at one negedge belongs to the digit whose anode is low at the next one.
   task automatic read_frame(input bit nb, output logic [15:0] obs);
      logic [3:0] prev_d;
      int         k;
      obs = 16'bx;
      @(negedge clk);
      prev_d = nb ? d_nb : d;
      for (int c = 0; c < 4*CLK_DIV + 1; c++) begin
         @(negedge clk);
         k = an_index(nb ? an_nb : an);
         if (k >= 0) obs[k*4 +: 4] = prev_d;
         prev_d = nb ? d_nb : d;
      end
   endtask

   task automatic finish_conv(input string name, input int pre, input bit chk_old,
                              input logic [15:0] old);
      int          n, n_nb, guard, k;
      logic [3:0]  prev_d;
      logic [15:0] obs, exp_v;
      n      = pre;
      n_nb   = pre;
      guard  = 0;
      prev_d = d;
      while ((busy || busy_nb) && guard < 40) begin
         guard++;
         if (busy)    n++;
         if (busy_nb) n_nb++;
         @(negedge clk);
         if (chk_old) begin
            k = an_index(an);
            if (k >= 0) begin
               checks++;
               if (prev_d !== old[k*4 +: 4]) begin
                  errors++;
                  $display("FAIL %s_old_digit%0d got %h want %h", name, k, prev_d, old[k*4 +: 4]);
               end
            end
         end
         prev_d = d;
      end
      checks++;
      if (n !== 14) begin
         errors++;
         $display("FAIL %s_busy_len got %0d want 14", name, n);
      end
      checks++;
      if (n_nb !== 14) begin
         errors++;
         $display("FAIL %s_busy_len_nb got %0d want 14", name, n_nb);
      end
      checks++;
      if (sb_q.size() == 0 || sb_nb_q.size() == 0) begin
         errors++;
         $display("FAIL %s_scoreboard got empty queue want entry", name);
      end else begin
         exp_v = sb_q.pop_front();
         read_frame(1'b0, obs);
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s_frame got %h want %h", name, obs, exp_v);
         end
         exp_v = sb_nb_q.pop_front();
         read_frame(1'b1, obs);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s_frame_nb got %h want %h", name, obs, exp_v);
         end
      end
   endtask

   task automatic test_reset();
      logic [3:0] exp_an;
      rst  = 1'b1;
      load = 1'b0;
      repeat (3) @(negedge clk);
      checks += 6;
      if (d !== 4'hF)     begin errors++; $display("FAIL rst_d got %h want f", d); end
      if (an !== 4'hF)    begin errors++; $display("FAIL rst_an got %b want 1111", an); end
      if (busy !== 1'b0)  begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
      if (d_nb !== 4'hF)  begin errors++; $display("FAIL rst_d_nb got %h want f", d_nb); end
      if (an_nb !== 4'hF) begin errors++; $display("FAIL rst_an_nb got %b want 1111", an_nb); end
      if (busy_nb !== 1'b0) begin errors++; $display("FAIL rst_busy_nb got %b want 0", busy_nb); end
      rst = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         exp_an = (c < 2) ? 4'hF : ~(4'b0001 << (((c - 2) / CLK_DIV) % 4));
         checks += 2;
         if (an !== exp_an) begin
            errors++;
            $display("FAIL scan_an_c%0d got %b want %b", c, an, exp_an);
         end
         if (d !== 4'hF) begin
            errors++;
            $display("FAIL scan_blank_d_c%0d got %h want f", c, d);
         end
      end
   endtask

   task automatic test_basic();
      do_load(14'd1234, 1'b1);
      finish_conv("load_1234", 0, 1'b0, 16'h0);
   endtask

   task automatic test_blanking();
      do_load(14'd7, 1'b1);
      finish_conv("load_7", 0, 1'b0, 16'h0);
      do_load(14'd0, 1'b1);
      finish_conv("load_0", 0, 1'b0, 16'h0);
   endtask

   task automatic test_overflow();
      do_load(14'd10000, 1'b1);
      finish_conv("load_10000", 0, 1'b0, 16'h0);
      do_load(14'd16383, 1'b1);
      finish_conv("load_16383", 0, 1'b0, 16'h0);
      do_load(14'd9999, 1'b1);
      finish_conv("load_9999", 0, 1'b0, 16'h0);
   endtask

   task automatic test_ignore();
      do_load(14'd42, 1'b1);
      repeat (3) @(negedge clk);
      do_load(14'd5555, 1'b0);
      finish_conv("ignore_2nd", 5, 1'b1, 16'h9999);
   endtask

   task automatic test_reset_mid();
      logic [15:0] obs;
      int          seen;
      do_load(14'd1234, 1'b1);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks += 2;
      if (busy !== 1'b0)    begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
      if (busy_nb !== 1'b0) begin errors++; $display("FAIL midrst_busy_nb got %b want 0", busy_nb); end
      sb_q.delete();
      sb_nb_q.delete();
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (busy || busy_nb) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++;
         $display("FAIL midrst_busy_after got %0d busy cycles want 0", seen);
      end
      read_frame(1'b0, obs);
      checks++;
      if (obs !== 16'hFFFF) begin
         errors++;
         $display("FAIL midrst_bank got %h want ffff", obs);
      end
      read_frame(1'b1, obs);
      checks++;
      if (obs !== 16'hFFFF) begin
         errors++;
         $display("FAIL midrst_bank_nb got %h want ffff", obs);
      end
      do_load(14'd5678, 1'b1);
      finish_conv("after_midrst", 0, 1'b0, 16'h0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_blanking();
      test_overflow();
      test_ignore();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
